// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, prefetch queue, start/redirect/halt FSM.
// Define FETCH_PERF_EN to add fetch/stall/flush performance counters.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter int         DEPTH        = 2,
  parameter bit         HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [7:0]  instr_pc,
  output logic        halted,
  output logic        busy
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_stall,
  output logic [7:0]  perf_flush
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  localparam logic [7:0] START_PC = {RESET_PC[7:2], 2'b00};
  localparam logic [1:0] LAST     = 2'(DEPTH - 1);
  localparam logic [2:0] FULL     = 3'(DEPTH);

  state_t      state, state_nx;
  logic [7:0]  pc, pc_nx;
  logic [31:0] q_data [4];
  logic [7:0]  q_pc   [4];
  logic [1:0]  head, tail;
  logic [2:0]  count;
  logic        push, pop, flush, room;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign pop  = instr_valid && instr_ready;
  assign room = (count < FULL) || pop;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    push     = 1'b0;
    flush    = 1'b0;
    if (redirect_valid) begin
      state_nx = RUN;
      pc_nx    = {redirect_pc[7:2], 2'b00};
      flush    = 1'b1;
    end else if (start && state != RUN) begin
      state_nx = RUN;
      pc_nx    = START_PC;
    end else if (state == RUN && room) begin
      // A zero word stops fetch and is dropped; PC stays on it.
      if (HALT_ON_ZERO && imem_data == 32'h0) begin
        state_nx = HALT;
      end else begin
        push  = 1'b1;
        pc_nx = pc + 8'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= START_PC;
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 3'd0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (flush) begin
        head  <= 2'd0;
        tail  <= 2'd0;
        count <= 3'd0;
      end else begin
        if (push) tail <= next_ptr(tail);
        if (pop)  head <= next_ptr(head);
        count <= count + {2'b00, push} - {2'b00, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= imem_data;
      q_pc[tail]   <= pc;
    end
  end

  assign imem_addr   = pc;
  assign instr_valid = (count != 3'd0);
  assign instr       = instr_valid ? q_data[head] : 32'h0;
  assign instr_pc    = instr_valid ? q_pc[head] : 8'h00;
  assign halted      = (state == HALT);
  assign busy        = (state == RUN);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 16'h0;
      perf_stall   <= 16'h0;
      perf_flush   <= 8'h0;
    end else if (start) begin
      perf_fetched <= 16'h0;
      perf_stall   <= 16'h0;
      perf_flush   <= 8'h0;
    end else begin
      if (push && perf_fetched != 16'hFFFF)
        perf_fetched <= perf_fetched + 16'd1;
      if (busy && !push && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
      if (redirect_valid && perf_flush != 8'hFF)
        perf_flush <= perf_flush + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed start, backpressure,
// redirect, wrap, async reset and optional perf-counter scenarios.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        halted;
  logic        busy;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
  logic [7:0]  perf_flush;
`endif

  typedef struct packed {
    logic [31:0] w;
    logic [7:0]  a;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted),
    .busy           (busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  // Program image; unlisted words are nonzero and tagged with their address.
  function automatic logic [31:0] rom(input logic [7:0] a);
    case (a)
      8'h00:   return 32'hE04F000F;
      8'h04:   return 32'hE2801002;
      8'h08:   return 32'hE2802005;
      8'h0C:   return 32'h00000000;
      default: return {24'hA00000, a};
    endcase
  endfunction

  always_comb imem_data = rom(imem_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [7:0] a);
    exp_t e;
    e.w = w;
    e.a = a;
    sbq.push_back(e);
  endtask

  // Monitor: sample mid-cycle, after stimulus has settled.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_issue: got %h@%h, expected nothing",
                 instr, instr_pc);
      end else begin
        e = sbq.pop_front();
        chk("issue_instr", instr, e.w);
        chk("issue_pc", {24'h0, instr_pc}, {24'h0, e.a});
      end
    end
  end

  task automatic wait_halt();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (halted === 1'b1) break;
    end
    #1 chk("halt_reached", {31'h0, halted}, 32'd1);
    repeat (2) @(negedge clk);
    #1 chk("sb_drained", sbq.size(), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b0;
    #3;
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", {24'h0, instr_pc}, 32'd0);
    chk("rst_halted", {31'h0, halted}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_addr", {24'h0, imem_addr}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line program ending in a zero word.
    @(negedge clk);
    instr_ready = 1'b1;
    expect_word(32'hE04F000F, 8'h00);
    expect_word(32'hE2801002, 8'h04);
    expect_word(32'hE2802005, 8'h08);
    pulse_start();
    wait_halt();
    chk("halt_addr", {24'h0, imem_addr}, 32'h0C);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_1", {16'h0, perf_fetched}, 32'd3);
    chk("perf_flush_1", {24'h0, perf_flush}, 32'd0);
`endif

    // Backpressure fills the queue and holds the head.
    @(negedge clk);
    instr_ready = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    #1;
    chk("bp_valid", {31'h0, instr_valid}, 32'd1);
    chk("bp_instr", instr, 32'hE04F000F);
    chk("bp_pc", {24'h0, instr_pc}, 32'h00);
    chk("bp_addr", {24'h0, imem_addr}, 32'h08);
    chk("bp_busy", {31'h0, busy}, 32'd1);
    expect_word(32'hE04F000F, 8'h00);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    chk("bp_next_instr", instr, 32'hE2801002);
    chk("bp_next_pc", {24'h0, instr_pc}, 32'h04);
    chk("bp_next_addr", {24'h0, imem_addr}, 32'h0C);

    // Redirect with 04/08 queued: flush, then target 0x24.
    redirect_valid = 1'b1;
    redirect_pc    = 8'h25;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("redir_flush", {31'h0, instr_valid}, 32'd0);
    chk("redir_addr", {24'h0, imem_addr}, 32'h24);
    expect_word(32'hA0000024, 8'h24);
    expect_word(32'hA0000028, 8'h28);
    instr_ready = 1'b1;
    @(negedge clk);
    #1 chk("redir_head_pc", {24'h0, instr_pc}, 32'h24);
    @(negedge clk);

    // Redirect to 0xFC wraps through 0x00 and halts at 0x0C.
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFC;
    expect_word(32'hA00000FC, 8'hFC);
    expect_word(32'hE04F000F, 8'h00);
    expect_word(32'hE2801002, 8'h04);
    expect_word(32'hE2802005, 8'h08);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("wrap_flush", {31'h0, instr_valid}, 32'd0);
    wait_halt();

    // Asynchronous reset with two words queued.
    @(negedge clk);
    instr_ready = 1'b0;
    pulse_start();
    repeat (3) @(negedge clk);
    #1 chk("pre_rst_addr", {24'h0, imem_addr}, 32'h08);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, instr_valid}, 32'd0);
    chk("arst_busy", {31'h0, busy}, 32'd0);
    chk("arst_addr", {24'h0, imem_addr}, 32'h00);
    chk("arst_instr", instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_busy", {31'h0, busy}, 32'd0);
    chk("post_rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("post_rst_addr", {24'h0, imem_addr}, 32'h00);

    // Fresh run, then a redirect out of HALT.
    @(negedge clk);
    instr_ready = 1'b1;
    expect_word(32'hE04F000F, 8'h00);
    expect_word(32'hE2801002, 8'h04);
    expect_word(32'hE2802005, 8'h08);
    pulse_start();
    wait_halt();
`ifdef FETCH_PERF_EN
    chk("perf_fetched_2", {16'h0, perf_fetched}, 32'd3);
    chk("perf_flush_2", {24'h0, perf_flush}, 32'd0);
`endif
    expect_word(32'hE2801002, 8'h04);
    expect_word(32'hE2802005, 8'h08);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h04;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("halt_redir_busy", {31'h0, busy}, 32'd1);
    wait_halt();
`ifdef FETCH_PERF_EN
    chk("perf_flush_3", {24'h0, perf_flush}, 32'd1);
    chk("perf_fetched_3", {16'h0, perf_fetched}, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the 256-byte, word-addressed instruction memory for the ARM-subset core.
- Drives the memory address from an internal PC and captures each returned word into a small prefetch queue.
- Hands queued instructions, each tagged with its PC, to decode through a valid/ready handshake.
- Handles start, branch redirect/flush, and halt-on-zero-word. The instruction memory itself stays a pure combinational ROM.

Parameters:
- RESET_PC, 8'h00, PC loaded on start; bits [1:0] are ignored and forced to 0.
- DEPTH, 2, prefetch queue entries; legal values are 1 to 4.
- HALT_ON_ZERO, 1, when 1 a fetched word of 32'h00000000 halts fetch.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset; assertion takes effect immediately; deassertion is synchronous to clk.
- start  in  1  one-cycle pulse; begins fetching from RESET_PC.
- imem_addr  out  8  address to the instruction memory; always equals the PC.
- imem_data  in  32  combinational read data for imem_addr, valid in the same cycle.
- redirect_valid  in  1  branch taken; flush the queue and load redirect_pc.
- redirect_pc  in  8  branch target; bits [1:0] are forced to 0.
- instr_valid  out  1  the queue head is valid.
- instr_ready  in  1  decode accepts the queue head this cycle.
- instr  out  32  instruction word at the queue head.
- instr_pc  out  8  address of the queue head.
- halted  out  1  FSM is in HALT.
- busy  out  1  FSM is in RUN.

Behaviour:
- Reset values (async, rst_n low): FSM=IDLE, PC=RESET_PC, queue count=0, instr_valid=0, instr=0, instr_pc=0, halted=0, busy=0. imem_addr follows the PC, so it reads RESET_PC.
- FSM states:
  - IDLE: no fetch. start moves to RUN and loads PC=RESET_PC.
  - RUN: fetching.
    - HALTED_ON_ZERO (HALT_ON_ZERO=1 and imem_data==0 on a push cycle) moves to HALT. The zero word is not enqueued and the PC holds.
  - HALT: no fetch; the queue keeps draining to decode.
    - redirect_valid moves to RUN with PC=redirect_pc.
    - start moves to RUN with PC=RESET_PC.
  - Priority in every state: redirect_valid > start > zero-halt.
- Push rule (RUN only): push = (count<DEPTH) || (instr_valid && instr_ready).
  - On a push, enqueue {imem_data, PC} at the tail and set PC <= PC+4.
  - The 8-bit PC wraps modulo 256, so 8'hFC becomes 8'h00.
- Pop rule: pop = instr_valid && instr_ready. The head advances next cycle.
- Simultaneous push and pop when full is allowed; count is unchanged.
- Latency: the word at address A is at the queue head one cycle after A is presented on imem_addr with a push, assuming the queue was empty.
- Redirect cycle:
  - The queue is flushed (count<=0).
  - No push occurs; imem_data that cycle is discarded.
  - PC <= {redirect_pc[7:2],2'b00}.
  - A pop in the same cycle still counts as accepted by decode.
  - The first target word appears at the head 2 cycles after redirect_valid.
- instr and instr_pc hold their value while instr_valid=1 and instr_ready=0. They must not change until the pop.
- start while already in RUN is ignored.
- rst_n asserted mid-operation clears everything to the reset values; any in-flight queue contents are lost.
- The queue is a circular buffer with head/tail pointers mod DEPTH. count ranges 0 to DEPTH and never over- or underflows.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds three outputs:
  - perf_fetched (16): count of pushes.
  - perf_stall (16): RUN cycles with no push.
  - perf_flush (8): count of redirects.
- All three reset to 0, saturate at their maximum, and clear on start.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Program 0x00=E04F000F, 0x04=E2801002, 0x08=E2802005, 0x0C=0, instr_ready=1, start pulse -> instr/instr_pc sequence E04F000F@00, E2801002@04, E2802005@08; halted=1 after the zero word at 0x0C; the zero word is never issued.
- DEPTH=2, instr_ready=0 for 5 cycles after start -> count saturates at 2; PC stops at 0x08; instr stays E04F000F@00. Then set ready=1 -> 04 and 08 follow with no gap or duplicate.
- Queue holding 04 and 08, redirect_valid with redirect_pc=0x25 -> queue empties next cycle; the first issued word has instr_pc=0x24, 2 cycles after redirect.
- Redirect to 0xFC with non-zero words at 0xFC and 0x00 and HALT_ON_ZERO=0 -> instr_pc sequence FC, 00, 04 (wrap).
- rst_n dropped asynchronously mid-fetch with 2 queued -> instr_valid=0 and busy=0 immediately, imem_addr=RESET_PC; after release, IDLE until start.
- With FETCH_PERF_EN, run the first scenario -> perf_fetched=3, perf_flush=0. Issue one redirect -> perf_flush=1.
